// File: rtl/coin_conditioner.sv
// Coin front end: 2-flop sync + debounce per line, rising-edge events into a DEPTH-entry FIFO, one pulse per coin.
// Press-to-pulse latency DB_CYCLES+2 edges; bev=1 freezes the FIFO head, and an event arriving at a full FIFO is dropped and flagged.
module coin_conditioner #(
  parameter int DB_CYCLES = 4,
  parameter int DEPTH     = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     coin_half_raw,
  input  logic                     coin_one_raw,
  input  logic                     bev,
  output logic                     half,
  output logic                     one,
  output logic [$clog2(DEPTH):0]   pending,
  output logic                     coin_reject
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = $clog2(DEPTH);
  localparam int NW = $clog2(DB_CYCLES);

  // Bit 0 is the half channel, bit 1 the one channel.
  logic [1:0]    raw, s1, s2, lvl, lvl_d, ev;
  logic [NW-1:0] cnt [2];

  assign raw = {coin_one_raw, coin_half_raw};
  assign ev  = lvl & ~lvl_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1     <= '0;
      s2     <= '0;
      lvl    <= '0;
      lvl_d  <= '0;
      cnt[0] <= '0;
      cnt[1] <= '0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      lvl_d <= lvl;
      for (int c = 0; c < 2; c++) begin
        if (s2[c] == lvl[c]) begin
          cnt[c] <= '0;
        end else if (cnt[c] == NW'(DB_CYCLES - 1)) begin
          lvl[c] <= s2[c];
          cnt[c] <= '0;
        end else begin
          cnt[c] <= cnt[c] + NW'(1);
        end
      end
    end
  end

  logic          mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, free;
  logic          present, acc_h, acc_o;

  // A pop in the same cycle frees a slot for an incoming event.
  assign present = (count != '0) && !bev;
  assign free    = CW'(DEPTH) - count + CW'(present);
  assign acc_h   = ev[0] && (free != '0);
  assign acc_o   = ev[1] && (free > CW'(acc_h));

  assign half    = present && !mem[rd_ptr];
  assign one     = present &&  mem[rd_ptr];
  assign pending = count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      coin_reject <= 1'b0;
    end else begin
      if (present) rd_ptr <= rd_ptr + PW'(1);
      wr_ptr      <= wr_ptr + PW'(acc_h) + PW'(acc_o);
      count       <= count + CW'(acc_h) + CW'(acc_o) - CW'(present);
      coin_reject <= (ev[0] && !acc_h) || (ev[1] && !acc_o);
    end
  end

  always_ff @(posedge clk) begin
    if (acc_h) mem[wr_ptr] <= 1'b0;
    if (acc_o) mem[wr_ptr + PW'(acc_h)] <= 1'b1;
  end

endmodule

// File: doc/coin_conditioner.md
Name: coin_conditioner

Overview:
- Front end feeding the vending FSM: takes the raw, bouncy, asynchronous coin-switch lines (half, one).
- Synchronizes and debounces each line, then turns each debounced press into a coin event.
- Queues coin events in a small FIFO and presents them to the vending FSM as mutually exclusive single-cycle half/one pulses.
- Holds coins back while the FSM is dispensing (bev high), because the FSM ignores coins in its dispense states.

Parameters:
- DB_CYCLES, 4: consecutive stable cycles required before a debounced level changes (≥2).
- DEPTH, 4: coin-event FIFO depth (power of 2, ≥2).

Ports:
- clk  in  1  single system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- coin_half_raw  in  1  raw half-coin switch, asynchronous, active-high, may bounce.
- coin_one_raw  in  1  raw one-coin switch, asynchronous, active-high, may bounce.
- bev  in  1  dispense indicator from the vending FSM; 1 = FSM will not accept coins this cycle.
- half  out  1  one-cycle half-coin pulse to the vending FSM.
- one  out  1  one-cycle one-coin pulse to the vending FSM.
- pending  out  $clog2(DEPTH)+1  number of coin events currently queued.
- coin_reject  out  1  registered one-cycle pulse: a coin event was dropped because the FIFO was full.

Behaviour:
- Reset (reset=0, asynchronous) clears everything:
  - synchronizer flops, debounced levels, debounce counters, FIFO pointers and count, coin_reject all go to 0.
  - half=one=0 and pending=0 while in reset.
  - Queued coins are discarded.
- Per channel, identical logic:
  - Synchronizer: 2-flop chain s1→s2.
  - Debounce counter cnt (width $clog2(DB_CYCLES)) against debounced level lvl:
    - if s2==lvl, cnt<=0;
    - else if cnt==DB_CYCLES-1, lvl<=s2 and cnt<=0;
    - else cnt<=cnt+1.
  - Any bounce (s2 returning to lvl) restarts the count.
  - Event register lvl_d<=lvl. A coin event occurs in the cycle where lvl & !lvl_d.
  - Falling edges generate nothing.
- Latency:
  - Raw line first sampled high at edge k and held → lvl rises at edge k+DB_CYCLES+1, event enqueued at edge k+DB_CYCLES+2.
  - With an empty FIFO and bev=0, the pulse is visible in the cycle after edge k+DB_CYCLES+2.
- A raw line held high through reset release produces exactly one coin after debounce.
- FIFO entries are 1 bit (0=half, 1=one).
- Enqueue order within one cycle: half event first, then one event.
  - Both events need a free slot.
  - If only one slot is available, half is accepted and one is rejected.
- Capacity:
  - Free slots = DEPTH - count + (pop this cycle ? 1 : 0); a same-cycle pop frees a slot for enqueue.
  - count updates by (#enqueued - #popped), range 0..DEPTH.
- Drop: any event that cannot be enqueued is dropped; coin_reject=1 for the cycle after that edge. coin_reject is never sticky.
- Output (combinational from registered FIFO head and the bev input):
  - present = (count!=0) && !bev.
  - half = present && head==0; one = present && head==1.
  - Never both high.
- Pop occurs at the edge ending any cycle where present=1; the FIFO advances, and back-to-back coins issue on consecutive cycles.
- bev=1 freezes the FIFO head; enqueue continues while frozen.
- pending = count (registered).
- No FSM beyond the FIFO: pointer wrap is modulo DEPTH, and full/empty are derived from count, not from pointer equality.

Test Plan:
- Clean press, DB_CYCLES=4: coin_one_raw rises before edge 0 and holds 20 cycles → exactly one `one` pulse, in the cycle after edge 6; pending goes 0→1→0; half never high.
- Bounce: coin_half_raw toggles 1,0,1,0 on alternate cycles then holds high → counter restarts on each toggle; exactly one half pulse, DB_CYCLES+2 edges after the final rise.
- Simultaneous: both raw lines rise in the same cycle, FIFO empty, bev=0 → half pulse on cycle N, one pulse on cycle N+1; pending peaks at 2.
- Backpressure: bev=1 held 10 cycles while three coins (half,one,half) are enqueued → no pulses while bev=1, pending=3; after bev falls, pulses half,one,half on 3 consecutive cycles.
- Overflow, DEPTH=4: bev=1, five coin events → pending saturates at 4; one coin_reject pulse on the fifth; after release, exactly 4 pulses in enqueue order.
- Reset mid-operation: pending=2 with a debounce in progress; drive reset=0 asynchronously mid-cycle → half/one/pending/coin_reject go 0 immediately; after release with raw lines low, no pulses occur.
